// File: rtl/bu_exec_if.sv
// Issue-side bundle between the branch reservation station and the branch execution unit.
// The package carries the issued-entry layout shared by both ends.
package bu_exec_pkg;
  localparam int RS_PRF_AW = 7;
  localparam int RS_ROB_AW = 5;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [RS_PRF_AW-1:0] ps1;
    logic [RS_PRF_AW-1:0] ps2;
    logic [RS_PRF_AW-1:0] pd;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [RS_ROB_AW-1:0] rob_index;
  } rs_data;
endpackage

interface bu_exec_if;
  logic                valid_in;
  bu_exec_pkg::rs_data data_in;
  logic                fu_rdy;

  modport master (output valid_in, output data_in, input fu_rdy);
  modport slave  (input valid_in, input data_in, output fu_rdy);
endinterface

// File: rtl/bu_exec.sv
// Branch execution unit: two registered stages resolving BR/JAL/JALR,
// producing link writeback, completion, flush/redirect and saturating perf counters.
module bu_exec #(
  parameter int PRF_AW = bu_exec_pkg::RS_PRF_AW,
  parameter int ROB_AW = bu_exec_pkg::RS_ROB_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  bu_exec_if.slave          iss,
  output logic [PRF_AW-1:0] rf_raddr1,
  output logic [PRF_AW-1:0] rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  output logic              wb_valid,
  output logic [PRF_AW-1:0] wb_pd,
  output logic [31:0]       wb_data,
  output logic              done_valid,
  output logic [ROB_AW-1:0] done_rob_index,
  output logic              flush,
  output logic [ROB_AW-1:0] flush_tag,
  output logic [31:0]       flush_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mp_count
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic                s1_valid;
  bu_exec_pkg::rs_data s1_q;

  logic              s2_valid;
  logic              s2_taken;
  logic              s2_wb;
  logic [ROB_AW-1:0] s2_rob;
  logic [PRF_AW-1:0] s2_pd;
  logic [31:0]       s2_target;
  logic [31:0]       s2_link;

  logic [CNT_W-1:0]  br_q;
  logic [CNT_W-1:0]  mp_q;

  logic        accept;
  logic        s1_to_s2;
  logic        op_branch;
  logic        op_jal;
  logic        op_jalr;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        cmp_ltu;
  logic        cond_taken;
  logic        s1_taken;
  logic        s1_wb;
  logic [31:0] s1_target;
  logic [31:0] s1_link;

  // A flush kills everything younger: the S1 entry and whatever is offered this cycle.
  assign flush      = s2_valid & s2_taken;
  assign iss.fu_rdy = ~flush;
  assign accept     = iss.valid_in & ~flush;
  assign s1_to_s2   = s1_valid & ~flush;

  assign rf_raddr1 = s1_valid ? s1_q.ps1 : '0;
  assign rf_raddr2 = s1_valid ? s1_q.ps2 : '0;

  always_comb begin
    op_branch  = (s1_q.opcode == OP_BRANCH);
    op_jal     = (s1_q.opcode == OP_JAL);
    op_jalr    = (s1_q.opcode == OP_JALR);
    cmp_eq     = (rf_rdata1 == rf_rdata2);
    cmp_lt     = ($signed(rf_rdata1) < $signed(rf_rdata2));
    cmp_ltu    = (rf_rdata1 < rf_rdata2);
    cond_taken = 1'b0;
    case (s1_q.func3)
      3'b000:  cond_taken = cmp_eq;
      3'b001:  cond_taken = ~cmp_eq;
      3'b100:  cond_taken = cmp_lt;
      3'b101:  cond_taken = ~cmp_lt;
      3'b110:  cond_taken = cmp_ltu;
      3'b111:  cond_taken = ~cmp_ltu;
      default: cond_taken = 1'b0;
    endcase
    // Static not-taken prediction: any taken transfer redirects fetch.
    s1_taken  = op_jal | op_jalr | (op_branch & cond_taken);
    s1_target = op_jalr ? ((rf_rdata1 + s1_q.imm) & 32'hFFFF_FFFE)
                        : (s1_q.pc + s1_q.imm);
    s1_wb     = (op_jal | op_jalr) & (s1_q.pd != '0);
    s1_link   = s1_q.pc + 32'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_q <= iss.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_taken  <= 1'b0;
      s2_wb     <= 1'b0;
      s2_rob    <= '0;
      s2_pd     <= '0;
      s2_target <= '0;
      s2_link   <= '0;
    end else begin
      s2_valid <= s1_to_s2;
      if (s1_to_s2) begin
        s2_taken  <= s1_taken;
        s2_wb     <= s1_wb;
        s2_rob    <= s1_q.rob_index;
        s2_pd     <= s1_q.pd;
        s2_target <= s1_target;
        s2_link   <= s1_link;
      end
    end
  end

  assign done_valid     = s2_valid;
  assign done_rob_index = s2_valid ? s2_rob : '0;
  assign flush_tag      = flush ? s2_rob : '0;
  assign flush_pc       = flush ? s2_target : '0;
  assign wb_valid       = s2_valid & s2_wb;
  assign wb_pd          = wb_valid ? s2_pd : '0;
  assign wb_data        = wb_valid ? s2_link : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (s2_valid && (br_q != {CNT_W{1'b1}})) br_q <= br_q + 1'b1;
      if (flush && (mp_q != {CNT_W{1'b1}}))    mp_q <= mp_q + 1'b1;
    end
  end

  assign br_count = br_q;
  assign mp_count = mp_q;
endmodule
